// File: rtl/th99_disp_pkg.sv
// th99_disp_pkg: shared state encoding, slot map and polarity helper for the TH99CHLS display
package th99_disp_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  localparam int NUM_DIGITS = 7;
  localparam logic [2:0] SLOT_MIN0  = 3'd0;
  localparam logic [2:0] SLOT_MIN1  = 3'd1;
  localparam logic [2:0] SLOT_HOUR0 = 3'd2;
  localparam logic [2:0] SLOT_HOUR1 = 3'd3;
  localparam logic [2:0] SLOT_SIG0  = 3'd4;
  localparam logic [2:0] SLOT_SIG1  = 3'd5;
  localparam logic [2:0] SLOT_SIG2  = 3'd6;
  function automatic logic [6:0] polarity(input logic [6:0] lit, input logic on_high);
    return on_high ? lit : ~lit;
  endfunction
endpackage

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: round-robin 7-digit 7-segment scanner with frame snapshot and brightness gating
module digit_scan_ctrl
  import th99_disp_pkg::*;
#(
  parameter int BLANK_CYCLES = 16,
  parameter int TICK_LOG2    = 6,
  parameter bit SEG_ON_HIGH  = 1'b1,
  parameter bit DIG_ON_HIGH  = 1'b1
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] bright,
  input  logic [6:0] minute_digi0,
  input  logic [6:0] minute_digi1,
  input  logic [6:0] hour_digi0,
  input  logic [6:0] hour_digi1,
  input  logic [6:0] sig_digi0,
  input  logic [6:0] sig_digi1,
  input  logic [6:0] sig_digi2,
  output logic [6:0] seg,
  output logic [6:0] dig_sel,
  output logic       frame_start
);
  localparam int DRV = 16 << TICK_LOG2;
  localparam int CW  = $clog2(DRV > BLANK_CYCLES ? DRV : BLANK_CYCLES);

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bright_q, bright_d;
  logic            snap_en;
  logic            lit;
  logic [6:0]      snap_q [NUM_DIGITS];
  logic [6:0]      codes  [NUM_DIGITS];

  assign codes[SLOT_MIN0]  = minute_digi0;
  assign codes[SLOT_MIN1]  = minute_digi1;
  assign codes[SLOT_HOUR0] = hour_digi0;
  assign codes[SLOT_HOUR1] = hour_digi1;
  assign codes[SLOT_SIG0]  = sig_digi0;
  assign codes[SLOT_SIG1]  = sig_digi1;
  assign codes[SLOT_SIG2]  = sig_digi2;

  // Scheduler: blank/drive phase sequencing, slot advance and frame/slot-start sampling
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    bright_d = bright_q;
    snap_en  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = SLOT_MIN0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          idx_d    = SLOT_MIN0;
          cnt_d    = '0;
          bright_d = bright;
          snap_en  = 1'b1;
        end
        BLANK: begin
          state_d = cnt_q == CW'(BLANK_CYCLES - 1) ? DRIVE : BLANK;
          cnt_d   = cnt_q == CW'(BLANK_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        end
        DRIVE: begin
          if (cnt_q == CW'(DRV - 1)) begin
            state_d  = BLANK;
            cnt_d    = '0;
            bright_d = bright;
            idx_d    = idx_q == SLOT_SIG2 ? SLOT_MIN0 : idx_q + 3'd1;
            snap_en  = idx_q == SLOT_SIG2;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, slot index, phase counter and per-slot brightness registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= SLOT_MIN0;
      cnt_q    <= '0;
      bright_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      bright_q <= bright_d;
    end
  end

  // Frame-coherent copy of all digit codes, refreshed only at slot 0 blank entry
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) snap_q[k] <= '0;
    end else if (snap_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) snap_q[k] <= codes[k];
    end
  end

  // Outputs decoded purely from registered state so pads never see an input glitch
  always_comb begin
    lit         = state_q == DRIVE && (cnt_q >> TICK_LOG2) <= CW'(bright_q);
    seg         = polarity(lit ? snap_q[idx_q] : 7'h00, SEG_ON_HIGH);
    dig_sel     = polarity(state_q == DRIVE ? 7'h01 << idx_q : 7'h00, DIG_ON_HIGH);
    frame_start = state_q == BLANK && idx_q == SLOT_MIN0 && cnt_q == '0;
  end
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed self-checking bench for digit_scan_ctrl
module tb_digit_scan_ctrl;
  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] bright = 4'd15;
  logic [6:0] m0 = 7'h01, m1 = 7'h02, h0 = 7'h03, h1 = 7'h04, s0 = 7'h05, s1 = 7'h06, s2 = 7'h07;
  logic [6:0] seg_a, dig_a, seg_b, dig_b, seg_c, dig_c;
  logic       fs_a, fs_b, fs_c;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  digit_scan_ctrl #(.BLANK_CYCLES(2), .TICK_LOG2(0), .SEG_ON_HIGH(1'b1), .DIG_ON_HIGH(1'b1)) dut_a (
    .clock(clock), .rst_n(rst_n), .en(en), .bright(bright),
    .minute_digi0(m0), .minute_digi1(m1), .hour_digi0(h0), .hour_digi1(h1),
    .sig_digi0(s0), .sig_digi1(s1), .sig_digi2(s2),
    .seg(seg_a), .dig_sel(dig_a), .frame_start(fs_a));

  digit_scan_ctrl #(.BLANK_CYCLES(2), .TICK_LOG2(2), .SEG_ON_HIGH(1'b1), .DIG_ON_HIGH(1'b1)) dut_b (
    .clock(clock), .rst_n(rst_n), .en(en), .bright(bright),
    .minute_digi0(m0), .minute_digi1(m1), .hour_digi0(h0), .hour_digi1(h1),
    .sig_digi0(s0), .sig_digi1(s1), .sig_digi2(s2),
    .seg(seg_b), .dig_sel(dig_b), .frame_start(fs_b));

  digit_scan_ctrl #(.BLANK_CYCLES(2), .TICK_LOG2(0), .SEG_ON_HIGH(1'b0), .DIG_ON_HIGH(1'b0)) dut_c (
    .clock(clock), .rst_n(rst_n), .en(en), .bright(bright),
    .minute_digi0(m0), .minute_digi1(m1), .hour_digi0(h0), .hour_digi1(h1),
    .sig_digi0(s0), .sig_digi1(s1), .sig_digi2(s2),
    .seg(seg_c), .dig_sel(dig_c), .frame_start(fs_c));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves all DUTs in their first BLANK cycle of slot 0 (cycle index 0 of a frame)
  task automatic restart();
    en = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (seg_a !== 7'h00 || dig_a !== 7'h00 || fs_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_high seg=%h dig=%h fs=%b want 00 00 0", seg_a, dig_a, fs_a);
      end
      checks++;
      if (seg_c !== 7'h7F || dig_c !== 7'h7F || fs_c !== 1'b0) begin
        errors++;
        $display("FAIL reset_low seg=%h dig=%h fs=%b want 7f 7f 0", seg_c, dig_c, fs_c);
      end
    end
  endtask

  task automatic test_order();
    logic [6:0] es, ed;
    int sl, p, c;
    bright = 4'd15;
    restart();
    for (int n = 0; n <= 140; n++) begin
      c = n % 126;
      sl = c / 18;
      p = c % 18;
      ed = p < 2 ? 7'h00 : 7'(1 << sl);
      es = p < 2 ? 7'h00 : 7'(sl + 1);
      checks++;
      if (dig_a !== ed || seg_a !== es || fs_a !== (c == 0)) begin
        errors++;
        $display("FAIL order n=%0d seg=%h dig=%h fs=%b want %h %h %b", n, seg_a, dig_a, fs_a, es, ed, c == 0);
      end
      step();
    end
  endtask

  task automatic test_brightness(input logic [3:0] b0);
    logic [6:0] es, ed;
    logic [3:0] br;
    int sl, p;
    bright = b0;
    restart();
    for (int c = 0; c < 132; c++) begin
      sl = c / 66;
      p = c % 66;
      br = sl == 0 ? b0 : 4'd15;
      ed = p < 2 ? 7'h00 : 7'(1 << sl);
      es = (p >= 2 && ((p - 2) >> 2) <= int'(br)) ? 7'(sl + 1) : 7'h00;
      checks++;
      if (dig_b !== ed || seg_b !== es) begin
        errors++;
        $display("FAIL bright%0d c=%0d seg=%h dig=%h want %h %h", b0, c, seg_b, dig_b, es, ed);
      end
      if (c == 10) bright = 4'd15;
      step();
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] es;
    int sl, p;
    h0 = 7'h3F;
    restart();
    for (int c = 0; c < 180; c++) begin
      sl = (c % 126) / 18;
      p = (c % 126) % 18;
      if (sl == 2 && p >= 2) begin
        es = c < 126 ? 7'h3F : 7'h06;
        checks++;
        if (seg_a !== es) begin
          errors++;
          $display("FAIL snapshot c=%0d seg=%h want %h", c, seg_a, es);
        end
      end
      if (c == 20) h0 = 7'h06;
      step();
    end
    h0 = 7'h03;
  endtask

  task automatic test_enable_drop();
    restart();
    for (int c = 0; c < 77; c++) step();
    checks++;
    if (dig_a !== 7'h10 || seg_a !== 7'h05) begin
      errors++;
      $display("FAIL pre_drop seg=%h dig=%h want 05 10", seg_a, dig_a);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dig_a !== 7'h00 || seg_a !== 7'h00 || fs_a !== 1'b0) begin
        errors++;
        $display("FAIL drop_dark i=%0d seg=%h dig=%h fs=%b want 00 00 0", i, seg_a, dig_a, fs_a);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (fs_a !== 1'b1 || dig_a !== 7'h00) begin
      errors++;
      $display("FAIL reen_fs fs=%b dig=%h want 1 00", fs_a, dig_a);
    end
    step();
    checks++;
    if (fs_a !== 1'b0 || dig_a !== 7'h00) begin
      errors++;
      $display("FAIL reen_blank fs=%b dig=%h want 0 00", fs_a, dig_a);
    end
    step();
    checks++;
    if (dig_a !== 7'h01 || seg_a !== 7'h01) begin
      errors++;
      $display("FAIL reen_slot0 seg=%h dig=%h want 01 01", seg_a, dig_a);
    end
  endtask

  task automatic test_polarity_reset();
    bright = 4'd15;
    restart();
    checks++;
    if (seg_c !== 7'h7F || dig_c !== 7'h7F || fs_c !== 1'b1) begin
      errors++;
      $display("FAIL pol_blank seg=%h dig=%h fs=%b want 7f 7f 1", seg_c, dig_c, fs_c);
    end
    for (int c = 0; c < 59; c++) step();
    checks++;
    if (dig_c !== 7'h77 || seg_c !== 7'h7B) begin
      errors++;
      $display("FAIL pol_slot3 seg=%h dig=%h want 7b 77", seg_c, dig_c);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg_c !== 7'h7F || dig_c !== 7'h7F) begin
      errors++;
      $display("FAIL async_rst_low seg=%h dig=%h want 7f 7f", seg_c, dig_c);
    end
    checks++;
    if (seg_a !== 7'h00 || dig_a !== 7'h00) begin
      errors++;
      $display("FAIL async_rst_high seg=%h dig=%h want 00 00", seg_a, dig_a);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_order();
    test_brightness(4'd0);
    test_brightness(4'd7);
    test_snapshot();
    test_enable_drop();
    test_polarity_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
